hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Stall/flush generator for the 5-stage MIPS pipeline; the other half of hazard resolution beside forwarding.
- Forwarding moves results that already exist; this block holds the pipeline when a result cannot exist yet: load-use, decode-stage branch operands, and the multi-cycle MUL/DIV unit.
- Tracks MUL/DIV occupancy with an internal state machine and counter.
- Drives the stall enables of the F/D/E pipeline registers and the flush of the D->E register.

Parameters:
- MUL_CYCLES, 4, execute cycles for MULT/MULTU (>=1)
- DIV_CYCLES, 32, execute cycles for DIV/DIVU (>=1)

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- RsAddrD  in  5  rs of instruction in decode
- RtAddrD  in  5  rt of instruction in decode
- BranchD  in  1  decode instruction is a branch/jr needing rs/rt in D
- HiLoReadD  in  1  decode instruction is MFHI/MFLO
- RAddrE  in  5  destination register in execute
- RegWriteE  in  1  execute instruction writes RAddrE
- MemReadE  in  1  execute instruction is a load
- RAddrM  in  5  destination register in memory
- MemReadM  in  1  memory-stage instruction is a load
- MulDivStartE  in  1  execute instruction is MULT/MULTU/DIV/DIVU
- MulDivOpE  in  1  0 = multiply, 1 = divide
- StallF  out  1  hold PC
- StallD  out  1  hold F->D register
- StallE  out  1  hold D->E register
- FlushE  out  1  insert bubble into D->E register
- MulDivBusy  out  1  MUL/DIV unit occupied
- MulDivDone  out  1  one-cycle pulse, HI/LO written at the end of this cycle
- StallCount  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (nRST low, asynchronous): state IDLE, counter 0.
  - All outputs read 0 while nRST is low, regardless of the other inputs.
- Register 0 never creates a hazard: any address compare against 0 is false.
- Load-use:
  - Condition: MemReadE & RAddrE!=0 & (RAddrE==RsAddrD | RAddrE==RtAddrD).
  - Response: StallF=StallD=FlushE=1.
- Branch operand (all terms gated by BranchD):
  - Condition: (RegWriteE & RAddrE!=0 & RAddrE matches RsAddrD or RtAddrD) | (MemReadM & RAddrM!=0 & RAddrM matches RsAddrD or RtAddrD).
  - Response: StallF=StallD=FlushE=1.
- MUL/DIV state machine, 2 states: IDLE, BUSY.
  - IDLE & MulDivStartE: load counter with (MulDivOpE ? DIV_CYCLES : MUL_CYCLES)-1; BUSY next cycle. The start is accepted this cycle with no stall.
  - BUSY & counter!=0: decrement by 1.
  - BUSY & counter==0: MulDivDone=1; IDLE next cycle.
  - MulDivBusy=1 whenever state is BUSY, including the Done cycle. A unit with N cycles shows exactly N Busy cycles after the accept cycle.
- Counter width is $clog2(max(MUL_CYCLES,DIV_CYCLES)); minimum 1 bit.
- HiLoReadD while BUSY (including the Done cycle): StallF=StallD=FlushE=1. Released in the first IDLE cycle.
- MulDivStartE while BUSY (including the Done cycle):
  - StallF=StallD=StallE=1 and FlushE=0; the start is not accepted.
  - It is accepted in the first IDLE cycle; back-to-back operations therefore have a 1-cycle gap.
- Combination rules when several conditions are active in one cycle:
  - StallE=1 forces FlushE=0; freezing the execute instruction takes precedence over the bubble.
  - Stall/flush outputs are the OR of all active conditions. StallE is only ever asserted together with StallF and StallD.
- All stall/flush outputs are combinational from inputs and registered state, with zero-cycle latency. No combinational path exists from a stall output back to an input.
- Reset asserted mid-operation: BUSY is aborted immediately and counter cleared. No MulDivDone pulse is produced.

Optional Feature:
- Macro HAZARD_STALL_COUNT_EN.
- Defined:
  - StallCount increments by 1 on every clock where StallF=1.
  - Saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: StallCount is tied to 32'h0 and no counter flops are inferred.

Test Plan:
- Load-use: MemReadE=1, RAddrE=5, RsAddrD=5 -> StallF=StallD=FlushE=1, StallE=0. Repeat with RAddrE=0 -> all 0.
- Branch hazard: BranchD=1, RtAddrD=9 with either RegWriteE=1,RAddrE=9 or MemReadM=1,RAddrM=9 -> stall+flush. With BranchD=0 -> no stall.
- MUL latency: MulDivStartE=1, MulDivOpE=0 at cycle 0 -> MulDivBusy=1 in cycles 1-4, MulDivDone=1 in cycle 4 only, IDLE in cycle 5. DIV: Busy in cycles 1-32, Done in cycle 32.
- MFHI during DIV: HiLoReadD=1 held from cycle 3 -> stall+flush in cycles 3-32, released in cycle 33.
- Back-to-back: second MulDivStartE held from cycle 2 during MUL -> StallE=1 and FlushE=0 in cycles 2-4. Accepted in cycle 5; new Busy in cycles 6-9.
- Reset in cycle 10 of a DIV -> all outputs 0 immediately, no Done pulse. After release, state IDLE. With HAZARD_STALL_COUNT_EN, StallCount=0.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/flush generator for the 5-stage MIPS pipeline.
// Holds the front end when a source operand cannot exist yet. The three
// causes are a load-use hazard, a decode-stage branch operand, and the
// multi-cycle MUL/DIV unit. MUL/DIV occupancy is tracked by a two-state
// FSM and a down-counter.
// Optional feature: define HAZARD_STALL_COUNT_EN to build a saturating
// 32-bit counter of StallF cycles on StallCount. Without it, StallCount
// reads 0 and no counter flops exist.
module hazard_stall_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [4:0]  RsAddrD,
  input  logic [4:0]  RtAddrD,
  input  logic        BranchD,
  input  logic        HiLoReadD,
  input  logic [4:0]  RAddrE,
  input  logic        RegWriteE,
  input  logic        MemReadE,
  input  logic [4:0]  RAddrM,
  input  logic        MemReadM,
  input  logic        MulDivStartE,
  input  logic        MulDivOpE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushE,
  output logic        MulDivBusy,
  output logic        MulDivDone,
  output logic [31:0] StallCount
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUSY} md_state_t;

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_done;
  logic             w_busy;

  // MUL/DIV state and remaining-cycle counter; reset aborts any operation.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: accept a start in IDLE, count down in BUSY, pulse Done at zero.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MulDivStartE) begin
          w_cnt_nxt   = MulDivOpE ? DIV_LOAD : MUL_LOAD;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_busy = (r_state == S_BUSY);

  // Hazard detection. Register 0 never matches anything.
  logic w_e_match;
  logic w_m_match;
  logic w_load_use;
  logic w_branch;
  logic w_hilo;
  logic w_md_hold;
  logic w_bubble;

  assign w_e_match  = (RAddrE != 5'd0) && ((RAddrE == RsAddrD) || (RAddrE == RtAddrD));
  assign w_m_match  = (RAddrM != 5'd0) && ((RAddrM == RsAddrD) || (RAddrM == RtAddrD));
  assign w_load_use = MemReadE && w_e_match;
  assign w_branch   = BranchD && ((RegWriteE && w_e_match) || (MemReadM && w_m_match));
  assign w_hilo     = HiLoReadD && w_busy;
  // A second MUL/DIV in execute must be frozen in place, not squashed.
  assign w_md_hold  = MulDivStartE && w_busy;
  assign w_bubble   = w_load_use || w_branch || w_hilo;

  // Outputs are forced low while reset is held, whatever the inputs do.
  assign StallF     = nRST && (w_bubble || w_md_hold);
  assign StallD     = nRST && (w_bubble || w_md_hold);
  assign StallE     = nRST && w_md_hold;
  assign FlushE     = nRST && w_bubble && !w_md_hold;
  assign MulDivBusy = nRST && w_busy;
  assign MulDivDone = nRST && w_done;

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] r_stall_count;

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_count <= 32'h0;
    end else if (StallF && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign StallCount = r_stall_count;
`else
  assign StallCount = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: table-driven vectors, hand-written multi-cycle
// sequences, and a randomized run against a remaining-cycles model.
module tb_hazard_stall_unit;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [4:0]  RsAddrD, RtAddrD, RAddrE, RAddrM;
  logic        BranchD, HiLoReadD, RegWriteE, MemReadE, MemReadM;
  logic        MulDivStartE, MulDivOpE;
  logic        StallF, StallD, StallE, FlushE, MulDivBusy, MulDivDone;
  logic [31:0] StallCount;

  hazard_stall_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .CLK(CLK), .nRST(nRST),
    .RsAddrD(RsAddrD), .RtAddrD(RtAddrD), .BranchD(BranchD), .HiLoReadD(HiLoReadD),
    .RAddrE(RAddrE), .RegWriteE(RegWriteE), .MemReadE(MemReadE),
    .RAddrM(RAddrM), .MemReadM(MemReadM),
    .MulDivStartE(MulDivStartE), .MulDivOpE(MulDivOpE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushE(FlushE),
    .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone), .StallCount(StallCount)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles of MUL/DIV occupancy still to come, plus stall tally.
  int          m_left = 0;
  int unsigned m_cnt  = 0;
  logic        e_sf, e_se, e_fl, e_busy, e_done;

  task automatic model_outs();
    logic lu, br, hl, md, busy, e_hit, m_hit;
    busy  = (m_left > 0);
    e_hit = (RAddrE != 0) && (RAddrE == RsAddrD || RAddrE == RtAddrD);
    m_hit = (RAddrM != 0) && (RAddrM == RsAddrD || RAddrM == RtAddrD);
    lu = MemReadE && e_hit;
    br = BranchD && ((RegWriteE && e_hit) || (MemReadM && m_hit));
    hl = HiLoReadD && busy;
    md = MulDivStartE && busy;
    e_sf   = nRST && (lu || br || hl || md);
    e_se   = nRST && md;
    e_fl   = nRST && (lu || br || hl) && !md;
    e_busy = nRST && busy;
    e_done = nRST && (m_left == 1);
  endtask

  function automatic logic [31:0] exp_count();
`ifdef HAZARD_STALL_COUNT_EN
    return m_cnt;
`else
    return 32'h0;
`endif
  endfunction

  task automatic clear_inputs();
    RsAddrD = 0; RtAddrD = 0; BranchD = 0; HiLoReadD = 0;
    RAddrE = 0; RegWriteE = 0; MemReadE = 0; RAddrM = 0; MemReadM = 0;
    MulDivStartE = 0; MulDivOpE = 0;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  // Update the model with the inputs of this cycle, then cross the clock edge.
  task automatic advance();
    model_outs();
    if (!nRST) begin
      m_left = 0;
      m_cnt  = 0;
    end else begin
      if (e_sf && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (m_left > 0) m_left--;
      else if (MulDivStartE) m_left = MulDivOpE ? DIV_N : MUL_N;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_model(input string tag);
    model_outs();
    check({tag, " StallF"}, StallF, e_sf);
    check({tag, " StallD"}, StallD, e_sf);
    check({tag, " StallE"}, StallE, e_se);
    check({tag, " FlushE"}, FlushE, e_fl);
    check({tag, " Busy"}, MulDivBusy, e_busy);
    check({tag, " Done"}, MulDivDone, e_done);
    check({tag, " StallCount"}, StallCount, exp_count());
  endtask

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       br, hilo;
    logic [4:0] re;
    logic       rwe, mre;
    logic [4:0] rm;
    logic       mrm;
    logic [3:0] exp;   // {StallF, StallD, StallE, FlushE}
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"lu_rs",       5, 0, 0, 0, 5, 0, 1, 0, 0, 4'b1101};
    vecs[1]  = '{"lu_r0",       0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000};
    vecs[2]  = '{"lu_rt",       1, 7, 0, 0, 7, 0, 1, 0, 0, 4'b1101};
    vecs[3]  = '{"lu_nomatch",  6, 7, 0, 0, 5, 0, 1, 0, 0, 4'b0000};
    vecs[4]  = '{"br_e",        0, 9, 1, 0, 9, 1, 0, 0, 0, 4'b1101};
    vecs[5]  = '{"br_m",        0, 9, 1, 0, 0, 0, 0, 9, 1, 4'b1101};
    vecs[6]  = '{"nobr_e",      0, 9, 0, 0, 9, 1, 0, 0, 0, 4'b0000};
    vecs[7]  = '{"nobr_m",      0, 9, 0, 0, 0, 0, 0, 9, 1, 4'b0000};
    vecs[8]  = '{"br_e_r0",     0, 3, 1, 0, 0, 1, 0, 0, 0, 4'b0000};
    vecs[9]  = '{"br_m_r0",     3, 0, 1, 0, 0, 0, 0, 0, 1, 4'b0000};
    vecs[10] = '{"br_e_miss",   4, 2, 1, 0, 3, 1, 0, 0, 0, 4'b0000};
    vecs[11] = '{"hilo_idle",   0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0000};

    // Reset: outputs held at zero even with hazard inputs active.
    nRST = 1'b0;
    clear_inputs();
    MemReadE = 1; RAddrE = 5; RsAddrD = 5; HiLoReadD = 1; MulDivStartE = 1;
    settle();
    check("rst StallF", StallF, 0);
    check("rst FlushE", FlushE, 0);
    check("rst StallE", StallE, 0);
    check("rst Busy", MulDivBusy, 0);
    check("rst StallCount", StallCount, 0);
    advance();
    nRST = 1'b1;
    clear_inputs();
    settle();
    advance();

    // Table-driven combinational vectors in IDLE.
    for (int i = 0; i < 12; i++) begin
      clear_inputs();
      RsAddrD = vecs[i].rs; RtAddrD = vecs[i].rt; BranchD = vecs[i].br;
      HiLoReadD = vecs[i].hilo; RAddrE = vecs[i].re; RegWriteE = vecs[i].rwe;
      MemReadE = vecs[i].mre; RAddrM = vecs[i].rm; MemReadM = vecs[i].mrm;
      settle();
      check({"vec ", vecs[i].name}, {28'h0, StallF, StallD, StallE, FlushE}, {28'h0, vecs[i].exp});
      check({"vec busy ", vecs[i].name}, MulDivBusy, 0);
      check({"vec cnt ", vecs[i].name}, StallCount, exp_count());
      advance();
    end
    clear_inputs();

    // MUL latency: Busy cycles 1-4, Done in cycle 4, idle in 5.
    for (int c = 0; c <= 5; c++) begin
      MulDivStartE = (c == 0); MulDivOpE = 0;
      settle();
      check($sformatf("mul busy c%0d", c), MulDivBusy, (c >= 1 && c <= 4));
      check($sformatf("mul done c%0d", c), MulDivDone, (c == 4));
      check($sformatf("mul stallF c%0d", c), StallF, 0);
      advance();
    end

    // DIV with MFHI held from cycle 3: stall+flush in 3-32, released in 33.
    for (int c = 0; c <= 33; c++) begin
      MulDivStartE = (c == 0); MulDivOpE = 1; HiLoReadD = (c >= 3);
      settle();
      check($sformatf("div busy c%0d", c), MulDivBusy, (c >= 1 && c <= 32));
      check($sformatf("div done c%0d", c), MulDivDone, (c == 32));
      check($sformatf("div stallF c%0d", c), StallF, (c >= 3 && c <= 32));
      check($sformatf("div flushE c%0d", c), FlushE, (c >= 3 && c <= 32));
      check($sformatf("div stallE c%0d", c), StallE, 0);
      advance();
    end
    clear_inputs();

    // Back-to-back MUL: second start held from cycle 2, accepted in 5.
    for (int c = 0; c <= 10; c++) begin
      MulDivStartE = (c == 0) || (c >= 2 && c <= 5); MulDivOpE = 0;
      settle();
      check($sformatf("b2b busy c%0d", c), MulDivBusy, (c >= 1 && c <= 4) || (c >= 6 && c <= 9));
      check($sformatf("b2b stallE c%0d", c), StallE, (c >= 2 && c <= 4));
      check($sformatf("b2b stallF c%0d", c), StallF, (c >= 2 && c <= 4));
      check($sformatf("b2b flushE c%0d", c), FlushE, 0);
      check($sformatf("b2b done c%0d", c), MulDivDone, (c == 4) || (c == 9));
      advance();
    end
    clear_inputs();

    // Reset in cycle 10 of a DIV: immediate zeros, no Done afterwards.
    for (int c = 0; c <= 9; c++) begin
      MulDivStartE = (c == 0); MulDivOpE = 1;
      settle();
      check($sformatf("rdiv busy c%0d", c), MulDivBusy, (c >= 1));
      advance();
    end
    clear_inputs();
    nRST = 1'b0;
    HiLoReadD = 1; MulDivStartE = 1; MemReadE = 1; RAddrE = 5; RsAddrD = 5;
    #1;
    check("midrst busy", MulDivBusy, 0);
    check("midrst stallF", StallF, 0);
    check("midrst stallE", StallE, 0);
    check("midrst flushE", FlushE, 0);
    check("midrst done", MulDivDone, 0);
    settle();
    check("midrst cnt", StallCount, 0);
    advance();
    nRST = 1'b1;
    clear_inputs();
    HiLoReadD = 1;
    settle();
    check("postrst hilo stallF", StallF, 0);
    check("postrst busy", MulDivBusy, 0);
    check("postrst cnt", StallCount, 0);
    advance();
    HiLoReadD = 0;
    for (int c = 0; c < 30; c++) begin
      settle();
      check($sformatf("postrst nodone c%0d", c), {31'h0, MulDivDone}, 0);
      check($sformatf("postrst idle c%0d", c), {31'h0, MulDivBusy}, 0);
      advance();
    end

    // Randomized run against the model, with occasional resets.
    for (int c = 0; c < 600; c++) begin
      nRST         = ($urandom_range(0, 49) != 0);
      RsAddrD      = 5'($urandom_range(0, 3));
      RtAddrD      = 5'($urandom_range(0, 3));
      RAddrE       = 5'($urandom_range(0, 3));
      RAddrM       = 5'($urandom_range(0, 3));
      BranchD      = ($urandom_range(0, 2) == 0);
      HiLoReadD    = ($urandom_range(0, 3) == 0);
      RegWriteE    = $urandom_range(0, 1);
      MemReadE     = ($urandom_range(0, 3) == 0);
      MemReadM     = ($urandom_range(0, 3) == 0);
      MulDivStartE = ($urandom_range(0, 3) == 0);
      MulDivOpE    = ($urandom_range(0, 3) == 0);
      settle();
      check_model($sformatf("rand c%0d", c));
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
